// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the data-memory path and the store unit.
package riscv_pkg;

    // Data memory geometry
    localparam int unsigned DMEM_DEPTH = 1024;

    // load_control encodings
    localparam logic [2:0] LB     = 3'b000;
    localparam logic [2:0] LH     = 3'b001;
    localparam logic [2:0] LW     = 3'b010;
    localparam logic [2:0] LBU    = 3'b100;
    localparam logic [2:0] LHU    = 3'b101;
    localparam logic [2:0] LD_NOP = 3'b111;

    // Store encodings, kept alongside the loads for the store unit
    localparam logic [1:0] SB     = 2'b00;
    localparam logic [1:0] SH     = 2'b01;
    localparam logic [1:0] SW     = 2'b10;

    // True for the five load codes that actually perform a load
    function automatic logic is_load(input logic [2:0] ctrl);
        return (ctrl == LB) || (ctrl == LH) || (ctrl == LW) ||
               (ctrl == LBU) || (ctrl == LHU);
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks byte/halfword/word at the offset,
// sign- or zero-extends it, and flags misaligned accesses (which return 0).
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  control,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = raw_word[8*offset +: 8];
    assign sel_half = offset[1] ? raw_word[31:16] : raw_word[15:0];

    // Extraction, extension and misalignment detection
    always_comb begin
        load_data  = '0;
        misaligned = 1'b0;
        case (control)
            LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
            LBU: load_data = {24'h0, sel_byte};
            LH: begin
                misaligned = offset[0];
                if (!offset[0]) load_data = {{16{sel_half[15]}}, sel_half};
            end
            LHU: begin
                misaligned = offset[0];
                if (!offset[0]) load_data = {16'h0, sel_half};
            end
            LW: begin
                misaligned = (offset != 2'b00);
                if (offset == 2'b00) load_data = raw_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: DEPTH x 32-bit storage, byte-enabled right-justified
// writes, one-cycle registered loads aligned/extended by load_align.
// Build option: DMEM_WR_FWD_EN forwards a same-cycle write into a load of the
// same word; without it the load sees the pre-write value.
module dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     mem_rw_mode,
    input  logic [$clog2(DEPTH)-1:0] mem_addr,
    input  logic [31:0]              mem_write_data,
    input  logic [3:0]               mem_byte_en,
    input  logic                     load_req,
    input  logic [31:0]              load_addr,
    input  logic [2:0]               load_control,
    output logic [31:0]              load_data,
    output logic                     load_valid,
    output logic                     load_misaligned
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];

    logic          wr_en;
    logic [31:0]   wr_word;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic [31:0]   fwd_word;

    logic          valid_d, valid_q;
    logic [2:0]    ctrl_d, ctrl_q;
    logic [1:0]    off_d, off_q;
    logic [31:0]   word_d, word_q;

    logic [31:0]   align_data;
    logic          align_mis;

    assign wr_en  = mem_rw_mode && (mem_byte_en != 4'b0000) && !i_rst;
    assign rd_idx = load_addr[AW+1:2];
    assign rd_word = mem_q[rd_idx];

    // Write steering: lane k takes the data byte whose index is the number of
    // enabled lanes below k, so right-justified data lands in the chosen lanes.
    always_comb begin
        wr_word = '0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] rank;
            rank = 2'd0;
            for (int j = 0; j < k; j++) begin
                rank = rank + {1'b0, mem_byte_en[j]};
            end
            wr_word[8*k +: 8] = mem_write_data[8*rank +: 8];
        end
    end

    // Storage array; intentionally not reset
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_byte_en[k]) mem_q[mem_addr][8*k +: 8] <= wr_word[8*k +: 8];
            end
        end
    end

    // Forwarding mux: merge the in-progress write into a same-word load
    always_comb begin
        fwd_word = rd_word;
`ifdef DMEM_WR_FWD_EN
        if (wr_en && (mem_addr == rd_idx)) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_byte_en[k]) fwd_word[8*k +: 8] = wr_word[8*k +: 8];
            end
        end
`endif
    end

    // Next state of the load pipeline register
    always_comb begin
        valid_d = load_req && is_load(load_control);
        ctrl_d  = load_control;
        off_d   = load_addr[1:0];
        word_d  = fwd_word;
    end

    // Load pipeline register; reset drops any request and in-flight response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= LD_NOP;
            off_q   <= 2'b00;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            off_q   <= off_d;
            word_q  <= word_d;
        end
    end

    load_align u_load_align (
        .raw_word   (word_q),
        .offset     (off_q),
        .control    (ctrl_q),
        .load_data  (align_data),
        .misaligned (align_mis)
    );

    assign load_valid      = valid_q;
    assign load_data       = valid_q ? align_data : 32'h0;
    assign load_misaligned = valid_q && align_mis;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: loads push expected responses, a monitor
// pops and compares on every load_valid pulse.
module tb_dmem_ctrl;
    import riscv_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        mem_rw_mode;
    logic [9:0]  mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_en;
    logic        load_req;
    logic [31:0] load_addr;
    logic [2:0]  load_control;
    logic [31:0] load_data;
    logic        load_valid;
    logic        load_misaligned;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 i_clk = ~i_clk;

    dmem_ctrl dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .mem_rw_mode     (mem_rw_mode),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_byte_en     (mem_byte_en),
        .load_req        (load_req),
        .load_addr       (load_addr),
        .load_control    (load_control),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .load_misaligned (load_misaligned)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge i_clk) begin
        if (load_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_load_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("load_data", load_data, e.data);
                check("load_misaligned", {31'h0, load_misaligned}, {31'h0, e.mis});
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        mem_rw_mode = 1'b0;
        load_req    = 1'b0;
        load_control = LD_NOP;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        mem_rw_mode = 1'b1; mem_addr = a; mem_write_data = d; mem_byte_en = be;
        step();
        idle();
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] c,
                      input logic [31:0] d, input logic m);
        exp_t e;
        e.data = d; e.mis = m;
        exp_q.push_back(e);
        load_req = 1'b1; load_addr = a; load_control = c;
        step();
        idle();
    endtask

    initial begin
        i_rst = 1'b1;
        mem_addr = '0; mem_write_data = '0; mem_byte_en = '0; load_addr = '0;
        idle();
        step(); step();
        @(negedge i_clk);
        check("reset_load_valid", {31'h0, load_valid}, 32'h0);
        check("reset_load_data", load_data, 32'h0);
        check("reset_load_misaligned", {31'h0, load_misaligned}, 32'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Full word then byte merge into word 5
        wr(10'd5, 32'h8765_4321, 4'b1111);
        ld(32'h14, LW, 32'h8765_4321, 1'b0);
        wr(10'd5, 32'h0000_00AA, 4'b0100);
        ld(32'h16, LB,  32'hFFFF_FFAA, 1'b0);
        ld(32'h16, LBU, 32'h0000_00AA, 1'b0);
        ld(32'h14, LW,  32'h87AA_4321, 1'b0);
        ld(32'h17, LB,  32'hFFFF_FF87, 1'b0);
        ld(32'h15, LBU, 32'h0000_0043, 1'b0);
        ld(32'h14, LH,  32'h0000_4321, 1'b0);
        ld(32'h16, LW,  32'h0, 1'b1);
        ld(32'h1000_0014, LW, 32'h87AA_4321, 1'b0);  // wraps modulo 4 KiB

        // Halfword into upper lanes of word 7
        wr(10'd7, 32'h0000_0000, 4'b1111);
        wr(10'd7, 32'h0000_8001, 4'b1100);
        ld(32'h1E, LH,  32'hFFFF_8001, 1'b0);
        ld(32'h1E, LHU, 32'h0000_8001, 1'b0);
        ld(32'h1D, LH,  32'h0, 1'b1);
        ld(32'h1C, LW,  32'h8001_0000, 1'b0);

        // Same-cycle write and load to word 9
        wr(10'd9, 32'h2222_2222, 4'b1111);
        mem_rw_mode = 1'b1; mem_addr = 10'd9; mem_write_data = 32'h1111_1111;
        mem_byte_en = 4'b1111;
`ifdef DMEM_WR_FWD_EN
        ld(32'h24, LW, 32'h1111_1111, 1'b0);
`else
        ld(32'h24, LW, 32'h2222_2222, 1'b0);
`endif
        ld(32'h24, LW, 32'h1111_1111, 1'b0);

        // Back-to-back loads of words 0..2
        wr(10'd0, 32'hA0A0_0000, 4'b1111);
        wr(10'd1, 32'hB1B1_0001, 4'b1111);
        wr(10'd2, 32'hC2C2_0002, 4'b1111);
        ld(32'h0, LW, 32'hA0A0_0000, 1'b0);
        ld(32'h4, LW, 32'hB1B1_0001, 1'b0);
        ld(32'h8, LW, 32'hC2C2_0002, 1'b0);

        // Reset in a request cycle drops the load
        step();
        i_rst = 1'b1; load_req = 1'b1; load_addr = 32'h0; load_control = LW;
        step();
        i_rst = 1'b0; idle();
        @(negedge i_clk);
        check("rst_drop_valid", {31'h0, load_valid}, 32'h0);
        check("rst_drop_data", load_data, 32'h0);

        // Reset during a write suppresses it
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        wr(10'd0, 32'hDEAD_BEEF, 4'b1111);
        i_rst = 1'b0;
        ld(32'h0, LW, 32'hA0A0_0000, 1'b0);

        // Undefined control code behaves as LD_NOP
        load_req = 1'b1; load_addr = 32'h0; load_control = 3'b011;
        step();
        idle();
        @(negedge i_clk);
        check("bad_code_no_valid", {31'h0, load_valid}, 32'h0);

        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
